// File: rtl/nose_acc_pkg.sv
// Shared defaults, FSM state type and saturating-add helper
// for the product accumulator stage.
package nose_acc_pkg;

  localparam int ACC_W_D     = 80;
  localparam int CNT_W_D     = 16;
  localparam int MAX_TERMS_D = 1024;

  // Widest accumulator the helper supports.
  localparam int SUM_MAX_W = 128;

  localparam logic [SUM_MAX_W:0] WIDE_ONE =
    (SUM_MAX_W+1)'(1);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_e;

  typedef struct packed {
    logic                 sat;
    logic [SUM_MAX_W-1:0] sum;
  } add_res_t;

  // a + b clamped to w bits. a must already fit in w bits.
  function automatic add_res_t sat_add(
    input logic [SUM_MAX_W-1:0] a,
    input logic [63:0]          b,
    input int                   w
  );
    logic [SUM_MAX_W:0] s;
    logic [SUM_MAX_W:0] lim;
    add_res_t           r;
    s   = {1'b0, a}
        + {{(SUM_MAX_W-63){1'b0}}, b};
    lim = (WIDE_ONE << w) - WIDE_ONE;
    r.sat = (s > lim);
    r.sum = r.sat ? lim[SUM_MAX_W-1:0]
                  : s[SUM_MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in, dot-product result out (valid/ready).
// master: producer/consumer side; slave: the accumulator.
interface product_accumulator_if #(
  parameter int ACC_W = 80,
  parameter int CNT_W = 16
);

  logic [63:0]      prod;
  logic             prod_valid;
  logic             prod_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_terms;
  logic             out_sat;
  logic             out_len_err;

  modport master (
    output prod, prod_valid, prod_last,
    output out_ready,
    input  in_ready, out_valid,
    input  out_sum, out_terms,
    input  out_sat, out_len_err
  );

  modport slave (
    input  prod, prod_valid, prod_last,
    input  out_ready,
    output in_ready, out_valid,
    output out_sum, out_terms,
    output out_sat, out_len_err
  );

endinterface

// File: rtl/acc_result_reg.sv
// One-entry valid/ready result register; drives in_ready.
// Ports: i_load new result, i_ready drain, o_* payload.
module acc_result_reg #(
  parameter int ACC_W = 80,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_sum,
  input  logic [CNT_W-1:0] i_terms,
  input  logic             i_sat,
  input  logic             i_len_err,
  input  logic             i_ready,
  output logic             o_in_ready,
  output logic             o_valid,
  output logic [ACC_W-1:0] o_sum,
  output logic [CNT_W-1:0] o_terms,
  output logic             o_sat,
  output logic             o_len_err
);

  logic             r_valid;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_terms;
  logic             r_sat;
  logic             r_len_err;

  assign o_in_ready = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_sum     <= '0;
      r_terms   <= '0;
      r_sat     <= 1'b0;
      r_len_err <= 1'b0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_sum     <= i_sum;
      r_terms   <= i_terms;
      r_sat     <= i_sat;
      r_len_err <= i_len_err;
    end else if (i_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_sum     = r_sum;
  assign o_terms   = r_terms;
  assign o_sat     = r_sat;
  assign o_len_err = r_len_err;

endmodule

// File: rtl/product_accumulator.sv
// Sums a stream of 64-bit products into a saturating
// accumulator; ports: clk, reset, bus (slave modport).
module product_accumulator
  import nose_acc_pkg::*;
#(
  parameter int ACC_W     = ACC_W_D,
  parameter int CNT_W     = CNT_W_D,
  parameter int MAX_TERMS = MAX_TERMS_D
) (
  input  logic                  clk,
  input  logic                  reset,
  product_accumulator_if.slave  bus
);

  state_e           r_state;
  state_e           w_state_nx;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  logic             w_in_ready;
  logic             w_take;
  logic             w_close;
  logic [CNT_W-1:0] w_cnt1;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_next;
  add_res_t         w_add;
  logic             w_unused;

  assign w_take = bus.prod_valid && w_in_ready;
  assign w_cnt1 = r_cnt + CNT_W'(1);
  assign w_close = w_take && (bus.prod_last
    || w_cnt1 == CNT_W'(MAX_TERMS));

  // IDLE always starts a fresh vector from zero.
  assign w_base = (r_state == ACCUM) ? r_acc : '0;
  assign w_add  = sat_add(SUM_MAX_W'(w_base),
                          bus.prod, ACC_W);
  assign w_next = w_add.sum[ACC_W-1:0];
  assign w_unused = ^w_add;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:  if (w_take && !w_close)
               w_state_nx = ACCUM;
      ACCUM: if (w_close)
               w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_take) begin
      if (w_close) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else begin
        r_acc <= w_next;
        r_cnt <= w_cnt1;
        r_sat <= r_sat | w_add.sat;
      end
    end
  end

  acc_result_reg #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_res (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_close),
    .i_sum      (w_next),
    .i_terms    (w_cnt1),
    .i_sat      (r_sat | w_add.sat),
    .i_len_err  (!bus.prod_last),
    .i_ready    (bus.out_ready),
    .o_in_ready (w_in_ready),
    .o_valid    (bus.out_valid),
    .o_sum      (bus.out_sum),
    .o_terms    (bus.out_terms),
    .o_sat      (bus.out_sat),
    .o_len_err  (bus.out_len_err)
  );

  assign bus.in_ready = w_in_ready;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: default-parameter DUT (a) and
// ACC_W=65 / MAX_TERMS=4 DUT (b) share one driver.
module tb_product_accumulator;

  typedef struct packed {
    logic [79:0] sum;
    logic [15:0] terms;
    logic        sat;
    logic        len_err;
  } res_t;

  localparam logic [79:0] P64 = 80'h1_0000_0000_0000_0000;
  localparam logic [79:0] M64 = 80'h0_FFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] M65 = 80'h1_FFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic [63:0] prod = '0;
  logic        pv = 1'b0;
  logic        pl = 1'b0;
  logic        ordy = 1'b1;
  logic        in_rdy;

  int   n_chk = 0;
  int   n_fail = 0;
  int   stalls = 0;
  res_t qa[$];
  res_t qb[$];

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(80), .CNT_W(16)) ia ();
  product_accumulator_if #(.ACC_W(65), .CNT_W(16)) ib ();

  assign ia.prod       = prod;
  assign ia.prod_valid = pv && !sel;
  assign ia.prod_last  = pl;
  assign ia.out_ready  = ordy;
  assign ib.prod       = prod;
  assign ib.prod_valid = pv && sel;
  assign ib.prod_last  = pl;
  assign ib.out_ready  = ordy;
  assign in_rdy = sel ? ib.in_ready : ia.in_ready;

  product_accumulator ua (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  product_accumulator #(
    .ACC_W     (65),
    .MAX_TERMS (4)
  ) ub (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic pop_cmp(input string nm,
                         input res_t got,
                         inout res_t q[$]);
    res_t e;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: unexpected result %0h, none queued",
               nm, got);
    end else begin
      e = q.pop_front();
      chk(nm, 128'(got), 128'(e));
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ia.out_valid && ia.out_ready)
      pop_cmp("result_a", {ia.out_sum, ia.out_terms,
              ia.out_sat, ia.out_len_err}, qa);
    if (!reset && ib.out_valid && ib.out_ready)
      pop_cmp("result_b", {15'd0, ib.out_sum, ib.out_terms,
              ib.out_sat, ib.out_len_err}, qb);
  end

  // Present one beat and hold it until accepted.
  task automatic beat(input logic [63:0] p,
                      input logic l);
    int n;
    n = 0;
    prod = p;
    pl   = l;
    pv   = 1'b1;
    @(negedge clk);
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (n >= 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    pv = 1'b0;
    pl = 1'b0;
  endtask

  task automatic push_a(input logic [79:0] s,
                        input int t,
                        input logic sa,
                        input logic le);
    qa.push_back('{s, 16'(t), sa, le});
  endtask

  task automatic push_b(input logic [79:0] s,
                        input int t,
                        input logic sa,
                        input logic le);
    qb.push_back('{s, 16'(t), sa, le});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 128'(ia.in_ready), 128'(1));
    chk("rst_out_valid", 128'(ia.out_valid), 128'(0));
    chk("rst_out_sum", 128'(ia.out_sum), 128'(0));
    chk("rst_out_terms", 128'(ia.out_terms), 128'(0));
    chk("rst_out_sat", 128'(ia.out_sat), 128'(0));
    chk("rst_len_err", 128'(ia.out_len_err), 128'(0));
    @(posedge clk);
    #1;

    // 3 + 5 + 7
    beat(64'd3, 1'b0);
    beat(64'd5, 1'b0);
    push_a(80'd15, 3, 1'b0, 1'b0);
    beat(64'd7, 1'b1);
    chk("latency_valid", 128'(ia.out_valid), 128'(1));
    @(posedge clk);
    #1;
    chk("valid_one_cycle", 128'(ia.out_valid), 128'(0));

    // back-to-back vectors, no bubble
    stalls = 0;
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    push_a(P64, 2, 1'b0, 1'b0);
    beat(64'd1, 1'b1);
    push_a(80'd10, 1, 1'b0, 1'b0);
    beat(64'd10, 1'b1);
    chk("no_bubble", 128'(stalls), 128'(0));
    @(posedge clk);
    #1;

    // output stall, then drain+refill
    ordy = 1'b0;
    push_a(80'd9, 1, 1'b0, 1'b0);
    beat(64'd9, 1'b1);
    prod = 64'd5;
    pl   = 1'b1;
    pv   = 1'b1;
    push_a(80'd5, 1, 1'b0, 1'b0);
    @(negedge clk);
    chk("stall_in_ready", 128'(ia.in_ready), 128'(0));
    @(negedge clk);
    chk("stall_sum", 128'(ia.out_sum), 128'(9));
    chk("stall_valid", 128'(ia.out_valid), 128'(1));
    @(posedge clk);
    #1 ordy = 1'b1;
    @(posedge clk);
    #1;
    pv = 1'b0;
    pl = 1'b0;
    chk("refill_valid", 128'(ia.out_valid), 128'(1));
    chk("refill_sum", 128'(ia.out_sum), 128'(5));
    @(posedge clk);
    #1;

    // reset mid-vector
    beat(64'd1, 1'b0);
    beat(64'd2, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("mid_rst_valid", 128'(ia.out_valid), 128'(0));
    chk("mid_rst_ready", 128'(ia.in_ready), 128'(1));
    push_a(80'd6, 1, 1'b0, 1'b0);
    beat(64'd6, 1'b1);
    @(posedge clk);
    #1;

    // narrow accumulator: saturation
    sel = 1'b1;
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    push_b(M65, 3, 1'b1, 1'b0);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    push_b(80'd4, 1, 1'b0, 1'b0);
    beat(64'd4, 1'b1);

    // term limit of 4
    for (int i = 0; i < 6; i++) begin
      if (i == 3) push_b(80'd4, 4, 1'b0, 1'b1);
      beat(64'd1, 1'b0);
    end
    push_b(80'd3, 3, 1'b0, 1'b0);
    beat(64'd1, 1'b1);

    // exact fit in 65 bits does not saturate
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    push_b(M65 - 80'd1, 2, 1'b0, 1'b0);
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("queue_a_empty", 128'(qa.size()), 128'(0));
    chk("queue_b_empty", 128'(qb.size()), 128'(0));
    chk("unused_m64", 128'(M64 + 80'd1), 128'(P64));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream stage of the 32x32 unsigned multiplier: consumes its 64-bit product stream, sums a vector of products into a wide unsigned accumulator and hands the completed dot-product to the next layer through a valid/ready output register. It sums one product per cycle and closes a vector on a `last` marker or on a hard term-count limit. Saturation and length errors are flagged per vector.

## Interface
- `ACC_W`, 80: accumulator and result width, ≥ 65.
- `CNT_W`, 16: term counter width.
- `MAX_TERMS`, 1024: forced vector close after this many terms; 1 ≤ MAX_TERMS ≤ 2^CNT_W − 1.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high; one clock and reset; polarity and synchronicity are fixed.
- `prod`  in  64  unsigned product from the multiplier.
- `prod_valid`  in  1  `prod` is valid this cycle. Upstream delays operand-valid by the multiplier's 2-cycle latency.
- `prod_last`  in  1  final term of the current vector; qualified by `prod_valid`.
- `in_ready`  out  1  beat accepted when `prod_valid && in_ready`.
- `out_valid`  out  1  result register holds a completed vector.
- `out_ready`  in  1  downstream accepts the result when `out_valid && out_ready`.
- `out_sum`  out  ACC_W  completed sum.
- `out_terms`  out  CNT_W  number of terms in the vector.
- `out_sat`  out  1  sum clamped at 2^ACC_W − 1 during the vector.
- `out_len_err`  out  1  vector was closed by MAX_TERMS, not by `prod_last`.

## Operation
- Internal state:
  - `acc` (ACC_W)
  - `cnt` (CNT_W)
  - `sat_sticky`
  - a one-entry result register (`out_*`)
  - FSM states `IDLE` (cnt = 0) and `ACCUM` (cnt > 0).
- Accepted beat: `next = acc + zero_extend(prod)`, computed at ACC_W+1 bits.
  - If bit ACC_W is set, `next` clamps to all-ones and `sat_sticky` is set.
  - `cnt` increments.
  - `IDLE` → `ACCUM`.
- Close condition: an accepted beat with `prod_last = 1`, or with `cnt + 1 == MAX_TERMS`.
- On close:
  - The result register loads `out_sum = next`, `out_terms = cnt + 1`, `out_sat = sat_sticky | this beat's saturation`, and `out_len_err = !prod_last`.
  - `out_valid` is set.
  - `acc`, `cnt` and `sat_sticky` clear, and the FSM returns to `IDLE`.
- A single-beat vector (`prod_last` on the first beat) is legal: `out_terms = 1`.
- `in_ready = !out_valid || out_ready`. This applies to all beats, closing or not.
- Beats presented while `in_ready = 0` are not consumed. Upstream must hold `prod`, `prod_valid` and `prod_last` stable until accepted.
- Drain and refill in the same cycle: when `out_valid && out_ready` coincides with an accepted closing beat, the register loads the new result and `out_valid` stays 1.
- Drain with no closing beat: `out_valid` clears.
- Reset mid-vector discards the partial sum and any unread result. There is no flush output.

## Timing
- Reset values:
  - `in_ready` = 1
  - `out_valid` = 0
  - `out_sum` = 0
  - `out_terms` = 0
  - `out_sat` = 0
  - `out_len_err` = 0
  - `acc` = 0, `cnt` = 0, `sat_sticky` = 0, FSM in `IDLE`.
- Latency: the closing beat is accepted at edge N, so `out_valid` and the result are visible after edge N. That is one cycle after the last product.
- Throughput: one beat per cycle, with back-to-back vectors at no bubble while `out_ready` stays high.
- `in_ready` is combinational from `out_valid` and `out_ready` only. There is no combinational path from `prod_valid` to `in_ready`.
- Outputs `out_*` are registered and stable while `out_valid && !out_ready`.

## Structure
- Shared package `nose_acc_pkg`:
  - default `ACC_W`, `CNT_W`, `MAX_TERMS`
  - FSM state enum {`IDLE`, `ACCUM`}
  - saturating-add helper function.
- One natural sub-module, `acc_result_reg`: the one-entry valid/ready output register, holding the payload `{sum, terms, sat, len_err}`. It generates `in_ready`.
- The accumulator datapath and FSM stay in the top module.

## Test plan
- Reset, then feed prods 3, 5, 7 with last on the third beat and `out_ready = 1` → `out_sum = 15`, `out_terms = 3`, `out_valid` for exactly 1 cycle, one cycle after the third beat.
- Two back-to-back vectors {2^64−1, 1} and {10} with `out_ready = 1` → results 2^64 / 2 terms, then 10 / 1 term. `in_ready` never drops.
- `ACC_W = 65`: feed 2^64−1 three times, last on the third → `out_sum` = 2^65−1, `out_sat = 1`. The following vector {4} → `out_sat = 0`.
- `MAX_TERMS = 4`: six beats of 1 with no last, then a beat of 1 with last →
  - first result: `out_sum = 4`, `out_terms = 4`, `out_len_err = 1`
  - second result: `out_sum = 3`, `out_terms = 3`, `out_len_err = 0`.
- Hold `out_ready = 0` after the vector {9} completes → `in_ready = 0`, the next beat (5, last) is held off and the result stays 9. Raise `out_ready` → 9 drains and 5 is accepted in the same cycle. `out_valid` stays high and then shows 5.
- Assert `reset` after two beats of a vector → `out_valid = 0`, `in_ready = 1`. A new vector {6} with last → `out_sum = 6`, `out_terms = 1`.
